// File: rtl/srt4_quotient_converter.sv
// srt4_quotient_converter: on-the-fly radix-4 SRT quotient conversion with final remainder sign correction
module srt4_quotient_converter #(
  parameter int NDIGITS = 8,
  parameter int QW = 2*NDIGITS
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          dig_valid,
  input  logic [2:0]    dig,
  output logic          dig_ready,
  input  logic          rem_valid,
  input  logic          rem_neg,
  output logic          rem_ready,
  output logic [QW-1:0] q,
  output logic          q_valid,
  output logic          busy,
  output logic          err
);
  localparam logic [1:0] S_IDLE = 2'd0, S_COLLECT = 2'd1, S_CORRECT = 2'd2, S_DONE = 2'd3;
  localparam int CW = $clog2(NDIGITS+1);
  logic [1:0]    r_state;
  logic [QW-1:0] r_q, r_qm, r_out;
  logic [CW-1:0] r_cnt;
  logic          r_err;
  logic          w_ill, w_pos;
  logic [QW-1:0] w_qsrc, w_qmsrc;
  assign w_ill = (dig == 3'b011) || (dig[2:1] == 2'b10);
  assign w_pos = !dig[2] && (dig != 3'b000);
  // Appended bits reduce to d mod 4 and (d-1) mod 4; only the source register depends on sign.
  assign w_qsrc = dig[2] ? r_qm : r_q;
  assign w_qmsrc = w_pos ? r_q : r_qm;
  assign dig_ready = r_state == S_COLLECT;
  assign rem_ready = r_state == S_CORRECT;
  assign q_valid = r_state == S_DONE;
  assign busy = r_state != S_IDLE;
  assign err = r_err;
  assign q = r_out;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_q <= '0;
      r_qm <= '1;
      r_cnt <= '0;
      r_out <= '0;
      r_err <= 1'b0;
    end else begin
      r_err <= 1'b0;
      if (start) begin
        r_state <= S_COLLECT;
        r_q <= '0;
        r_qm <= '1;
        r_cnt <= '0;
      end else begin
        case (r_state)
          S_COLLECT: if (dig_valid) begin
            if (w_ill) begin
              r_state <= S_IDLE;
              r_err <= 1'b1;
            end else begin
              r_q <= {w_qsrc[QW-3:0], dig[1:0]};
              r_qm <= {w_qmsrc[QW-3:0], dig[1:0] - 2'd1};
              r_cnt <= r_cnt + 1'b1;
              r_state <= (r_cnt == CW'(NDIGITS-1)) ? S_CORRECT : S_COLLECT;
            end
          end
          S_CORRECT: if (rem_valid) begin
            r_out <= rem_neg ? r_qm : r_q;
            r_state <= S_DONE;
          end
          S_DONE: r_state <= S_IDLE;
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_srt4_quotient_converter.sv
// tb_srt4_quotient_converter: randomized and directed checks against an arithmetic quotient model
module tb_srt4_quotient_converter;
  logic clk = 0, rst = 1, start = 0, dig_valid = 0, rem_valid = 0, rem_neg = 0;
  logic [2:0] dig = 0;
  logic dig_ready, rem_ready, q_valid, busy, err;
  logic [7:0] q;
  int n_tests = 0, n_fail = 0;
  logic [2:0] dv [4];
  logic [2:0] legal [5] = '{3'b000, 3'b001, 3'b010, 3'b110, 3'b111};

  srt4_quotient_converter #(.NDIGITS(4), .QW(8)) dut (
    .clk(clk), .rst(rst), .start(start), .dig_valid(dig_valid), .dig(dig),
    .dig_ready(dig_ready), .rem_valid(rem_valid), .rem_neg(rem_neg), .rem_ready(rem_ready),
    .q(q), .q_valid(q_valid), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  // Quotient = sum of d_i * 4^(3-i), minus one ulp when the remainder is negative, modulo 256
  function automatic logic [7:0] ref_q(input bit neg);
    int v = 0;
    for (int i = 0; i < 4; i++) v = v*4 + int'($signed(dv[i]));
    v = v - int'(neg);
    return 8'(v);
  endfunction

  task automatic feed(input int n);
    @(negedge clk); start = 1; dig_valid = 0; rem_valid = 0;
    @(negedge clk); start = 0; dig_valid = 1;
    for (int k = 0; k < n; k++) begin
      dig = dv[k];
      @(negedge clk);
    end
    dig_valid = 0;
  endtask

  task automatic do_job(input bit neg, input bit gappy, output logic [7:0] got,
                        output bit qv, output bit qv2, output bit rdy_ok, output bit to);
    int i = 0, t = 0;
    @(negedge clk); start = 1; dig_valid = 1; dig = 3'b010; rem_valid = 1; rem_neg = 0;
    @(negedge clk); start = 0; rem_valid = 0;
    while (i < 4 && t < 100) begin
      dig_valid = gappy ? 1'($urandom_range(0, 1)) : 1'b1;
      dig = dig_valid ? dv[i] : 3'($urandom);
      if (dig_valid && dig_ready) i++;
      t++;
      @(negedge clk);
    end
    dig_valid = 0;
    to = i < 4;
    rdy_ok = !dig_ready && rem_ready;
    if (gappy) repeat ($urandom_range(0, 3)) begin
      rem_neg = 1'($urandom);
      @(negedge clk);
    end
    rem_valid = 1; rem_neg = neg;
    @(negedge clk); rem_valid = 0;
    qv = q_valid; got = q;
    @(negedge clk); qv2 = q_valid;
  endtask

  task automatic test_reset;
    rst = 1;
    repeat (2) @(negedge clk);
    n_tests++;
    if ({q, dig_ready, rem_ready, q_valid, busy, err} !== 13'h0) begin
      n_fail++; $display("FAIL reset: got q=%h strobes=%b, want q=00 strobes=00000", q, {dig_ready, rem_ready, q_valid, busy, err});
    end
    rst = 0;
  endtask

  task automatic test_directed;
    logic [2:0] vec [4][4] = '{'{3'd1, 3'd1, 3'd1, 3'd1}, '{3'd1, 3'd1, 3'd1, 3'd1},
                               '{3'd2, 3'b111, 3'd0, 3'd1}, '{3'b111, 3'd2, 3'd2, 3'd2}};
    bit negs [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic [7:0] exp [4] = '{8'h55, 8'h54, 8'h71, 8'hEA};
    logic [7:0] got;
    bit qv, qv2, rdy, to;
    for (int j = 0; j < 4; j++) begin
      for (int k = 0; k < 4; k++) dv[k] = vec[j][k];
      do_job(negs[j], 1'b0, got, qv, qv2, rdy, to);
      n_tests++;
      if (got !== exp[j]) begin n_fail++; $display("FAIL directed_q[%0d]: got %h want %h", j, got, exp[j]); end
      n_tests++;
      if ({qv, qv2, rdy} !== 3'b101) begin n_fail++; $display("FAIL directed_handshake[%0d]: got qv=%b qv_next=%b rdy=%b want 1 0 1", j, qv, qv2, rdy); end
    end
  endtask

  task automatic test_random;
    logic [7:0] got, exp;
    bit qv, qv2, rdy, to, neg;
    for (int j = 0; j < 20; j++) begin
      for (int k = 0; k < 4; k++) dv[k] = legal[$urandom_range(0, 4)];
      neg = 1'($urandom);
      exp = ref_q(neg);
      do_job(neg, 1'b1, got, qv, qv2, rdy, to);
      n_tests++;
      if (to || got !== exp || !qv || qv2 || !rdy) begin
        n_fail++;
        $display("FAIL random[%0d]: got q=%h qv=%b qv_next=%b rdy=%b timeout=%b want q=%h 1 0 1 0", j, got, qv, qv2, rdy, to, exp);
      end
    end
  endtask

  task automatic test_illegal;
    logic [7:0] got, exp;
    bit qv, qv2, rdy, to, seen = 0;
    dv[0] = 3'd1; dv[1] = 3'b100;
    feed(2);
    n_tests++;
    if ({err, busy, dig_ready} !== 3'b100) begin n_fail++; $display("FAIL illegal_err: got err/busy/rdy=%b want 100", {err, busy, dig_ready}); end
    rem_valid = 1;
    @(negedge clk);
    n_tests++;
    if (err !== 1'b0) begin n_fail++; $display("FAIL illegal_pulse: err=%b want 0", err); end
    repeat (6) begin seen |= q_valid; @(negedge clk); end
    rem_valid = 0;
    n_tests++;
    if (seen) begin n_fail++; $display("FAIL illegal_no_qvalid: q_valid seen=1 want 0"); end
    for (int k = 0; k < 4; k++) dv[k] = legal[$urandom_range(0, 4)];
    exp = ref_q(1'b0);
    do_job(1'b0, 1'b0, got, qv, qv2, rdy, to);
    n_tests++;
    if (got !== exp || !qv) begin n_fail++; $display("FAIL illegal_recover: got q=%h qv=%b want %h 1", got, qv, exp); end
  endtask

  task automatic test_abort;
    logic [7:0] got, prev;
    bit qv, qv2, rdy, to;
    for (int k = 0; k < 4; k++) dv[k] = 3'd2;
    feed(2);
    for (int k = 0; k < 4; k++) dv[k] = 3'd1;
    do_job(1'b0, 1'b0, got, qv, qv2, rdy, to);
    n_tests++;
    if (got !== 8'h55 || !qv) begin n_fail++; $display("FAIL abort_collect: got q=%h qv=%b want 55 1", got, qv); end
    prev = q;
    for (int k = 0; k < 4; k++) dv[k] = 3'b110;
    feed(4);
    start = 1; rem_valid = 1; rem_neg = 1;
    @(negedge clk); start = 0; rem_valid = 0;
    n_tests++;
    if ({q_valid, dig_ready, rem_ready} !== 3'b010 || q !== prev) begin
      n_fail++; $display("FAIL abort_correct: got qv/rdy/rrdy=%b q=%h want 010 q=%h", {q_valid, dig_ready, rem_ready}, q, prev);
    end
  endtask

  task automatic test_rst_mid;
    n_tests++;
    if (q === 8'h00) begin n_fail++; $display("FAIL rst_mid_pre: q=%h want nonzero before reset", q); end
    for (int k = 0; k < 4; k++) dv[k] = 3'd1;
    feed(4);
    rst = 1; rem_valid = 1;
    @(negedge clk); rst = 0; rem_valid = 0;
    n_tests++;
    if ({q, dig_ready, rem_ready, q_valid, busy, err} !== 13'h0) begin
      n_fail++; $display("FAIL rst_mid: got q=%h strobes=%b want q=00 strobes=00000", q, {dig_ready, rem_ready, q_valid, busy, err});
    end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_random;
    test_illegal;
    test_abort;
    test_rst_mid;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
